// File: rtl/avr_uart_tx.sv
// 8N1 UART transmitter for the FPGA->AVR link, with flow control from the AVR's rx-busy line.
// Define AVR_UART_TX_FIFO_EN to buffer bytes in a FIFO_DEPTH-entry FIFO instead of one holding slot.
module avr_uart_tx #(
  parameter int unsigned CLK_PER_BIT = 50
`ifdef AVR_UART_TX_FIFO_EN
  , parameter int unsigned FIFO_DEPTH = 4
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       new_tx_data,
  output logic       tx_busy,
  input  logic       tx_block,
  output logic       tx
);
  localparam int unsigned CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] CntMax = CW'(CLK_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_d, busy_d;
  logic          blk_meta_q, blk_s;
  logic          avail, take;
  logic [7:0]    avail_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_meta_q <= 1'b0;
      blk_s      <= 1'b0;
    end else begin
      blk_meta_q <= tx_block;
      blk_s      <= blk_meta_q;
    end
  end

`ifdef AVR_UART_TX_FIFO_EN
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned NW = PW + 1;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [NW-1:0] count_q, count_d;
  logic          wr;

  assign wr         = new_tx_data & ~tx_busy;
  assign avail      = (count_q != '0);
  assign avail_data = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({wr, take})
      2'b10:   count_d = count_q + NW'(1);
      2'b01:   count_d = count_q - NW'(1);
      default: count_d = count_q;
    endcase
    busy_d = (count_d == NW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr)   wr_ptr_q <= wr_ptr_q + PW'(1);
      if (take) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end
`else
  logic       accept, pend_q, pend_d;
  logic [7:0] hold_q, hold_d;

  // A byte accepted while blk_s is high parks in hold_q until the block clears.
  assign accept     = new_tx_data & ~tx_busy;
  assign avail      = pend_q | accept;
  assign avail_data = pend_q ? hold_q : tx_data;

  always_comb begin
    pend_d = pend_q;
    hold_d = hold_q;
    if (accept) begin
      pend_d = 1'b1;
      hold_d = tx_data;
    end
    if (take) pend_d = 1'b0;
    busy_d = (state_d != StIdle) | pend_d | blk_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      hold_q <= '0;
    end else begin
      pend_q <= pend_d;
      hold_q <= hold_d;
    end
  end
`endif

  always_comb begin
    take    = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    unique case (state_q)
      StIdle: begin
        if (avail && !blk_s) begin
          take    = 1'b1;
          shift_d = avail_data;
          cnt_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == CntMax) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = StData;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StData: begin
        if (cnt_q == CntMax) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = StStop;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StStop: begin
        if (cnt_q == CntMax) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // tx is registered from the next state so the line moves exactly on bit boundaries.
    case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx      <= tx_d;
      tx_busy <= busy_d;
    end
  end

endmodule

// File: tb/tb_avr_uart_tx.sv
// Directed bench for avr_uart_tx at CLK_PER_BIT=4: frame vectors plus flow-control and reset cases.
module tb_avr_uart_tx;
  localparam int unsigned CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n, new_tx_data, tx_block, tx_busy, tx;
  logic [7:0] tx_data;
  int         total = 0;
  int         bad = 0;

  avr_uart_tx #(.CLK_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .new_tx_data(new_tx_data),
    .tx_busy    (tx_busy),
    .tx_block   (tx_block),
    .tx         (tx)
  );

  always #5 clk = ~clk;

  // frame bit 0 is sent first: {stop, data, start}
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;
  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    check($sformatf("accept %02h busy", d), {31'd0, tx_busy}, 32'd0);
    tx_data     = d;
    new_tx_data = 1'b1;
    tick();
    new_tx_data = 1'b0;
`ifdef AVR_UART_TX_FIFO_EN
    tick();
`endif
  endtask

  // Expects the start bit in the current cycle; optionally raises tx_block at frame bit blk_bit.
  task automatic recv(input logic [9:0] frame, input int blk_bit, input string name);
    logic [3:0] seen;
    int         busy_hi;
    busy_hi = 0;
    for (int b = 0; b < 10; b++) begin
      if (b == blk_bit) tx_block = 1'b1;
      for (int c = 0; c < int'(CPB); c++) begin
        seen[c] = tx;
        if (tx_busy) busy_hi++;
        tick();
      end
      check($sformatf("%s bit%0d", name, b), {28'd0, seen}, {28'd0, {4{frame[b]}}});
    end
`ifndef AVR_UART_TX_FIFO_EN
    check($sformatf("%s busy cycles", name), busy_hi, 32'd40);
`endif
  endtask

  initial begin
    logic txhi;
    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'h3C, 10'b1001111000};
    vecs[4] = '{8'h01, 10'b1000000010};
    vecs[5] = '{8'h80, 10'b1100000000};

    rst_n = 1'b0; tx_block = 1'b0; new_tx_data = 1'b0; tx_data = 8'h00;
    repeat (3) tick();
    check("reset tx", {31'd0, tx}, 32'd1);
    check("reset busy", {31'd0, tx_busy}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Each byte is strobed in the first idle cycle after the previous stop bit.
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].data);
      recv(vecs[i].frame, -1, $sformatf("vec%0d", i));
    end
    check("idle busy", {31'd0, tx_busy}, 32'd0);
    check("idle tx", {31'd0, tx}, 32'd1);

`ifndef AVR_UART_TX_FIFO_EN
    // Block first: strobe is ignored, line stays idle.
    tx_block = 1'b1;
    repeat (3) tick();
    check("blk busy", {31'd0, tx_busy}, 32'd1);
    tx_data = 8'h55; new_tx_data = 1'b1;
    tick();
    new_tx_data = 1'b0;
    txhi = 1'b1;
    repeat (20) begin txhi &= tx; tick(); end
    tx_block = 1'b0;
    tick();
    check("blk busy hold", {31'd0, tx_busy}, 32'd1);
    repeat (2) tick();
    check("unblk busy", {31'd0, tx_busy}, 32'd0);
    repeat (12) begin txhi &= tx; tick(); end
    check("blk tx idle", {31'd0, txhi}, 32'd1);

    // Strobe in the cycle blk_s rises: byte accepted and held until the block clears.
    tx_block = 1'b1;
    repeat (2) tick();
    check("simul busy before", {31'd0, tx_busy}, 32'd0);
    tx_data = 8'hC3; new_tx_data = 1'b1;
    tick();
    new_tx_data = 1'b0;
    check("simul busy held", {31'd0, tx_busy}, 32'd1);
    txhi = 1'b1;
    repeat (10) begin txhi &= tx; tick(); end
    check("simul tx idle", {31'd0, txhi}, 32'd1);
    tx_block = 1'b0;
    repeat (2) tick();
    check("simul tx pre", {31'd0, tx}, 32'd1);
    tick();
    recv(10'b1110000110, -1, "simul C3");
    check("simul busy after", {31'd0, tx_busy}, 32'd0);

    // Block raised mid-frame: frame completes, next byte waits for unblock.
    send(8'h5A);
    recv(10'b1010110100, 4, "midblk 5A");
    check("midblk busy", {31'd0, tx_busy}, 32'd1);
    tx_data = 8'h11; new_tx_data = 1'b1;
    tick();
    new_tx_data = 1'b0;
    txhi = 1'b1;
    repeat (8) begin txhi &= tx; tick(); end
    check("midblk tx idle", {31'd0, txhi}, 32'd1);
    tx_block = 1'b0;
    repeat (3) tick();
    send(8'h81);
    recv(10'b1100000010, -1, "after 81");

    // Asynchronous reset mid-DATA.
    send(8'h00);
    repeat (14) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst tx", {31'd0, tx}, 32'd1);
    check("arst busy", {31'd0, tx_busy}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send(8'h3C);
    recv(10'b1001111000, -1, "post rst 3C");
`else
    tx_block = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("fifo wr%0d busy", i), {31'd0, tx_busy}, (i < 4) ? 32'd0 : 32'd1);
      tx_data = vecs[i].data; new_tx_data = 1'b1;
      tick();
    end
    new_tx_data = 1'b0;
    check("fifo full busy", {31'd0, tx_busy}, 32'd1);
    txhi = 1'b1;
    repeat (5) begin txhi &= tx; tick(); end
    check("fifo blk tx idle", {31'd0, txhi}, 32'd1);
    tx_block = 1'b0;
    repeat (3) tick();
    check("fifo busy after pop", {31'd0, tx_busy}, 32'd0);
    recv(vecs[0].frame, -1, "fifo0");
    for (int i = 1; i < 4; i++) begin
      tick();
      recv(vecs[i].frame, -1, $sformatf("fifo%0d", i));
    end
    txhi = 1'b1;
    repeat (10) begin txhi &= tx; tick(); end
    check("fifo 5th dropped", {31'd0, txhi}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
